// File: rtl/fpu_add_seq.sv
// Sequential IEEE-754 single-precision adder/subtractor with a valid/ready request/response handshake.
// The operation steps through IDLE -> UNPACK -> EXEC -> DONE and can be abandoned at any point by flush_i.
module fpu_add_seq #(
   parameter int EXEC_CYCLES = 1
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic        sub_i,
   input  logic [2:0]  rm_i,
   input  logic        flush_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] result_o,
   output logic [4:0]  fflags_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, UNPACK, EXEC, DONE} state_t;

   state_t             state;
   logic [3:0]         cnt;
   logic               armed;
   logic [31:0]        op_a, op_b;
   logic [2:0]         rm_q;
   logic [5:0]         cls_a, cls_b;
   logic signed [10:0] exp_a, exp_b;
   logic [47:0]        sig_a, sig_b;

   // datapath nets
   logic [2:0]         rmode;
   logic               sgn_a, sgn_b, a_big, s_big, eff_sub;
   logic               nan_a, nan_b, inf_a, inf_b;
   logic signed [10:0] e_big, e_sml;
   logic [47:0]        m_big, m_sml, aligned;
   logic [11:0]        diff, e_top, room, e_res, bexp;
   logic [6:0]         sh;
   logic [95:0]        wide;
   logic               stk, g, st, inc, ovf;
   logic [49:0]        sum, norm;
   logic [5:0]         lead, lz, shamt;
   logic [24:0]        rnd;
   logic [22:0]        frac;
   logic [31:0]        ovf_res, dp_res;
   logic [4:0]         dp_flg;

   function automatic logic [5:0] classify(input logic [30:0] x);
      logic [5:0] c;
      if (x[30:23] == 8'h00)
         c = (x[22:0] == 23'd0) ? 6'b000001 : 6'b000010;
      else if (x[30:23] == 8'hFF)
         c = (x[22:0] == 23'd0) ? 6'b001000 : (x[22] ? 6'b100000 : 6'b010000);
      else
         c = 6'b000100;
      return c;
   endfunction

   function automatic logic signed [10:0] unbias(input logic [7:0] e);
      return (e == 8'h00) ? -11'sd126 : $signed({3'b000, e}) - 11'sd127;
   endfunction

   function automatic logic hidden(input logic [7:0] e);
      return (|e) & ~(&e);
   endfunction

   function automatic logic [5:0] lead_one(input logic [49:0] v);
      logic [5:0] p;
      p = 6'd0;
      for (int i = 0; i < 50; i++)
         if (v[i]) p = 6'(i);
      return p;
   endfunction

   always_comb begin
      rmode   = (rm_q > 3'b100) ? 3'b000 : rm_q;
      sgn_a   = op_a[31];
      sgn_b   = op_b[31];
      nan_a   = cls_a[4] | cls_a[5];
      nan_b   = cls_b[4] | cls_b[5];
      inf_a   = cls_a[3];
      inf_b   = cls_b[3];
      eff_sub = sgn_a ^ sgn_b;

      // order by magnitude so the subtraction never goes negative
      a_big = (exp_a > exp_b) || ((exp_a == exp_b) && (sig_a >= sig_b));
      e_big = a_big ? exp_a : exp_b;
      e_sml = a_big ? exp_b : exp_a;
      m_big = a_big ? sig_a : sig_b;
      m_sml = a_big ? sig_b : sig_a;
      s_big = a_big ? sgn_a : sgn_b;

      diff    = {e_big[10], e_big} - {e_sml[10], e_sml};
      sh      = (diff > 12'd48) ? 7'd48 : diff[6:0];
      wide    = {m_sml, 48'd0} >> sh;
      aligned = wide[95:48];
      stk     = |wide[47:0];
      sum     = eff_sub ? ({1'b0, m_big, 1'b0} - {1'b0, aligned, stk})
                        : ({1'b0, m_big, 1'b0} + {1'b0, aligned, stk});

      // normalize toward bit 49, but never below the subnormal exponent
      lead  = lead_one(sum);
      lz    = 6'd49 - lead;
      e_top = {e_big[10], e_big} + 12'd1;
      room  = e_top + 12'd126;
      shamt = (room < {6'd0, lz}) ? room[5:0] : lz;
      norm  = sum << shamt;
      e_res = e_top - {6'd0, shamt};
      g     = norm[25];
      st    = |norm[24:0];

      case (rmode)
         3'b001:  inc = 1'b0;
         3'b010:  inc = (g | st) & s_big;
         3'b011:  inc = (g | st) & ~s_big;
         3'b100:  inc = g;
         default: inc = g & (st | norm[26]);
      endcase
      rnd = {1'b0, norm[49:26]} + {24'd0, inc};

      if (rnd[24]) begin
         bexp = e_res + 12'd128;
         frac = rnd[23:1];
      end else if (rnd[23]) begin
         bexp = e_res + 12'd127;
         frac = rnd[22:0];
      end else begin
         bexp = 12'd0;
         frac = rnd[22:0];
      end
      ovf = (bexp >= 12'd255);

      case (rmode)
         3'b001:  ovf_res = {s_big, 8'hFE, 23'h7FFFFF};
         3'b010:  ovf_res = s_big ? {s_big, 8'hFF, 23'd0} : {s_big, 8'hFE, 23'h7FFFFF};
         3'b011:  ovf_res = s_big ? {s_big, 8'hFE, 23'h7FFFFF} : {s_big, 8'hFF, 23'd0};
         default: ovf_res = {s_big, 8'hFF, 23'd0};
      endcase

      dp_res = 32'd0;
      dp_flg = 5'd0;
      if (nan_a | nan_b) begin
         dp_res = 32'h7FC00000;
         dp_flg = {cls_a[4] | cls_b[4], 4'b0000};
      end else if (inf_a & inf_b) begin
         if (eff_sub) begin
            dp_res = 32'h7FC00000;
            dp_flg = 5'b10000;
         end else begin
            dp_res = {sgn_a, 8'hFF, 23'd0};
         end
      end else if (inf_a) begin
         dp_res = {sgn_a, 8'hFF, 23'd0};
      end else if (inf_b) begin
         dp_res = {sgn_b, 8'hFF, 23'd0};
      end else if (cls_a[0] & cls_b[0]) begin
         dp_res = {eff_sub ? (rmode == 3'b010) : sgn_a, 31'd0};
      end else if (cls_a[0]) begin
         dp_res = op_b;
      end else if (cls_b[0]) begin
         dp_res = op_a;
      end else if ((|cls_a[2:1]) && (|cls_b[2:1])) begin
         if (sum == 50'd0) begin
            dp_res = {rmode == 3'b010, 31'd0};
         end else if (ovf) begin
            dp_res = ovf_res;
            dp_flg = 5'b00101;
         end else begin
            dp_res = {s_big, bexp[7:0], frac};
            dp_flg = {3'b000, ~norm[49] & (g | st), g | st};
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         armed        <= 1'b0;
         req_ready_o  <= 1'b0;
         resp_valid_o <= 1'b0;
         busy_o       <= 1'b0;
         result_o     <= 32'd0;
         fflags_o     <= 5'd0;
         op_a         <= 32'd0;
         op_b         <= 32'd0;
         rm_q         <= 3'd0;
         cls_a        <= 6'd0;
         cls_b        <= 6'd0;
         exp_a        <= 11'sd0;
         exp_b        <= 11'sd0;
         sig_a        <= 48'd0;
         sig_b        <= 48'd0;
      end else if (flush_i) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         armed        <= 1'b0;
         req_ready_o  <= 1'b1;
         resp_valid_o <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               req_ready_o <= 1'b1;
               if (req_valid_i && req_ready_o) begin
                  op_a        <= rs1_i;
                  op_b        <= {rs2_i[31] ^ sub_i, rs2_i[30:0]};
                  rm_q        <= rm_i;
                  req_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
                  state       <= UNPACK;
               end
            end
            UNPACK: begin
               cls_a <= classify(op_a[30:0]);
               cls_b <= classify(op_b[30:0]);
               exp_a <= unbias(op_a[30:23]);
               exp_b <= unbias(op_b[30:23]);
               sig_a <= {hidden(op_a[30:23]), op_a[22:0], 24'd0};
               sig_b <= {hidden(op_b[30:23]), op_b[22:0], 24'd0};
               armed <= 1'b0;
               state <= EXEC;
            end
            EXEC: begin
               // first EXEC cycle arms the counter while the adder settles
               if (!armed) begin
                  cnt   <= 4'(EXEC_CYCLES - 1);
                  armed <= 1'b1;
               end else if (cnt == 4'd0) begin
                  result_o     <= dp_res;
                  fflags_o     <= dp_flg;
                  resp_valid_o <= 1'b1;
                  armed        <= 1'b0;
                  state        <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               if (resp_ready_i) begin
                  resp_valid_o <= 1'b0;
                  req_ready_o  <= 1'b1;
                  busy_o       <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_add_seq.sv
// Bench for fpu_add_seq: two instances (EXEC_CYCLES 1 and 4), expected results queued at request
// time and popped on each response; covers reset, arithmetic vectors, backpressure, flush and mid-op reset.
module tb_fpu_add_seq;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic [31:0] rs1, rs2;
   logic        sub;
   logic [2:0]  rm;
   logic        v0, f0, rr0, v1, f1, rr1;
   logic        rdy0, rv0, bz0, rdy1, rv1, bz1;
   logic [31:0] res0, res1;
   logic [4:0]  flg0, flg1;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  flg;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [2:0]  r;
      logic [31:0] res;
      logic [4:0]  flg;
   } vec_t;

   exp_t sb0[$];
   exp_t sb1[$];
   int   total = 0;
   int   bad   = 0;

   fpu_add_seq #(.EXEC_CYCLES(1)) u_dut (
      .clk_i(clk), .rstn_i(rstn), .req_valid_i(v0), .req_ready_o(rdy0),
      .rs1_i(rs1), .rs2_i(rs2), .sub_i(sub), .rm_i(rm), .flush_i(f0),
      .resp_valid_o(rv0), .resp_ready_i(rr0), .result_o(res0), .fflags_o(flg0), .busy_o(bz0)
   );

   fpu_add_seq #(.EXEC_CYCLES(4)) u_dut4 (
      .clk_i(clk), .rstn_i(rstn), .req_valid_i(v1), .req_ready_o(rdy1),
      .rs1_i(rs1), .rs2_i(rs2), .sub_i(sub), .rm_i(rm), .flush_i(f1),
      .resp_valid_o(rv1), .resp_ready_i(rr1), .result_o(res1), .fflags_o(flg1), .busy_o(bz1)
   );

   // Called at a negedge; returns at the negedge right after the acceptance edge with junk on the operand bus.
   task automatic send(input bit sel, input bit push, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [2:0] r, input logic [31:0] er, input logic [4:0] ef);
      int n = 0;
      while (((sel ? rdy1 : rdy0) !== 1'b1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      rs1 = a; rs2 = b; sub = s; rm = r;
      if (sel) v1 = 1'b1; else v0 = 1'b1;
      if (push) begin
         if (sel) sb1.push_back(exp_t'{er, ef});
         else     sb0.push_back(exp_t'{er, ef});
      end
      @(negedge clk);
      v0 = 1'b0; v1 = 1'b0;
      rs1 = $urandom; rs2 = $urandom; sub = 1'($urandom); rm = 3'($urandom);
   endtask

   task automatic wait_resp(input bit sel, output int cyc);
      cyc = 0;
      while (((sel ? rv1 : rv0) !== 1'b1) && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #2;
      total++;
      if ({rdy0, rv0, bz0, res0, flg0} !== 40'd0) begin
         bad++;
         $display("FAIL reset_hold: got %h want 0", {rdy0, rv0, bz0, res0, flg0});
      end
      repeat (2) @(negedge clk);
      total++;
      if ({rdy1, rv1, bz1, res1, flg1} !== 40'd0) begin
         bad++;
         $display("FAIL reset_hold4: got %h want 0", {rdy1, rv1, bz1, res1, flg1});
      end
      rstn = 1'b1;
      #1;
      total++;
      if (rdy0 !== 1'b0) begin
         bad++;
         $display("FAIL ready_before_edge: got %b want 0", rdy0);
      end
      @(negedge clk);
      total++;
      if ({rdy0, bz0} !== 2'b10) begin
         bad++;
         $display("FAIL ready_after_release: got %b want 10", {rdy0, bz0});
      end
   endtask

   task automatic test_vectors();
      vec_t vt[17];
      int   cyc;
      exp_t e;
      vt = '{
         '{32'h3F800000, 32'h40000000, 1'b0, 3'd0, 32'h40400000, 5'h00},
         '{32'h7F800000, 32'h7F800000, 1'b1, 3'd0, 32'h7FC00000, 5'h10},
         '{32'h7F800001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 5'h10},
         '{32'h3F800000, 32'h3F800000, 1'b1, 3'd2, 32'h80000000, 5'h00},
         '{32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 32'h00000000, 5'h00},
         '{32'h3F800000, 32'h33800000, 1'b0, 3'd0, 32'h3F800000, 5'h01},
         '{32'h3F800000, 32'h33800000, 1'b0, 3'd3, 32'h3F800001, 5'h01},
         '{32'h3F800000, 32'h33800000, 1'b0, 3'd4, 32'h3F800001, 5'h01},
         '{32'h3F800000, 32'h33800000, 1'b0, 3'd7, 32'h3F800000, 5'h01},
         '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 32'h7F800000, 5'h05},
         '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, 32'h7F7FFFFF, 5'h05},
         '{32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd3, 32'hFF7FFFFF, 5'h05},
         '{32'h7FC00000, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 5'h00},
         '{32'h00000001, 32'h00000001, 1'b0, 3'd0, 32'h00000002, 5'h00},
         '{32'h3F800000, 32'h3F400000, 1'b1, 3'd0, 32'h3E800000, 5'h00},
         '{32'hBF800000, 32'h3F000000, 1'b0, 3'd0, 32'hBF000000, 5'h00},
         '{32'h3F800000, 32'h00000000, 1'b1, 3'd0, 32'h3F800000, 5'h00}
      };
      rr0 = 1'b1;
      for (int i = 0; i < 17; i++) begin
         send(1'b0, 1'b1, vt[i].a, vt[i].b, vt[i].s, vt[i].r, vt[i].res, vt[i].flg);
         wait_resp(1'b0, cyc);
         total++;
         if (cyc !== 3) begin
            bad++;
            $display("FAIL latency[%0d]: got %0d want 3", i, cyc);
         end
         total++;
         if (sb0.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty[%0d]: got 0 entries want 1", i);
         end else begin
            e = sb0.pop_front();
            if ({res0, flg0} !== {e.res, e.flg}) begin
               bad++;
               $display("FAIL vec[%0d]: got %h/%b want %h/%b", i, res0, flg0, e.res, e.flg);
            end
         end
         @(negedge clk);
         total++;
         if ({rdy0, rv0, bz0} !== 3'b100) begin
            bad++;
            $display("FAIL idle_after_hs[%0d]: got %b want 100", i, {rdy0, rv0, bz0});
         end
      end
   endtask

   task automatic test_backpressure();
      int   cyc;
      exp_t e;
      rr0 = 1'b0;
      send(1'b0, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 32'h40000000, 5'h00);
      wait_resp(1'b0, cyc);
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({rv0, rdy0, res0, flg0} !== {2'b10, 32'h40000000, 5'h00}) begin
            bad++;
            $display("FAIL hold[%0d]: got %b%b %h %b want 10 40000000 00000", i, rv0, rdy0, res0, flg0);
         end
         @(negedge clk);
      end
      rr0 = 1'b1;
      total++;
      e = (sb0.size() != 0) ? sb0.pop_front() : exp_t'(37'h0);
      if ({rv0, res0, flg0} !== {1'b1, e.res, e.flg}) begin
         bad++;
         $display("FAIL bp_result: got %b %h %b want 1 %h %b", rv0, res0, flg0, e.res, e.flg);
      end
      @(negedge clk);
      total++;
      if ({rdy0, rv0, bz0} !== 3'b100) begin
         bad++;
         $display("FAIL bp_idle: got %b want 100", {rdy0, rv0, bz0});
      end
   endtask

   task automatic test_flush_idle();
      rs1 = 32'h3F800000; rs2 = 32'h3F800000; sub = 1'b0; rm = 3'd0;
      v0 = 1'b1; f0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0; f0 = 1'b0;
      total++;
      if ({bz0, rdy0} !== 2'b01) begin
         bad++;
         $display("FAIL flush_idle_accept: got busy/ready %b want 01", {bz0, rdy0});
      end
      repeat (4) @(negedge clk);
      total++;
      if (rv0 !== 1'b0) begin
         bad++;
         $display("FAIL flush_idle_resp: got %b want 0", rv0);
      end
   endtask

   task automatic test_flush();
      int   cyc;
      bit   seen;
      exp_t e;
      rr1 = 1'b1;
      send(1'b1, 1'b0, 32'h3F800000, 32'h40000000, 1'b0, 3'd0, 32'h0, 5'h0);
      repeat (2) @(negedge clk);
      f1 = 1'b1;
      @(negedge clk);
      f1 = 1'b0;
      total++;
      if ({bz1, rv1, rdy1} !== 3'b001) begin
         bad++;
         $display("FAIL flush_exec: got %b want 001", {bz1, rv1, rdy1});
      end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (rv1 !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL flush_no_resp: got a response want none");
      end
      send(1'b1, 1'b1, 32'h3FC00000, 32'h3E800000, 1'b0, 3'd0, 32'h3FE00000, 5'h00);
      wait_resp(1'b1, cyc);
      total++;
      if (cyc !== 6) begin
         bad++;
         $display("FAIL latency4: got %0d want 6", cyc);
      end
      total++;
      e = (sb1.size() != 0) ? sb1.pop_front() : exp_t'(37'h0);
      if ({res1, flg1} !== {e.res, e.flg}) begin
         bad++;
         $display("FAIL after_flush: got %h/%b want %h/%b", res1, flg1, e.res, e.flg);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int   cyc;
      exp_t e;
      // park a nonzero result first so the asynchronous clear is observable
      send(1'b0, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 32'h40000000, 5'h00);
      wait_resp(1'b0, cyc);
      void'(sb0.pop_front());
      @(negedge clk);
      send(1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 32'h0, 5'h0);
      total++;
      if (bz0 !== 1'b1) begin
         bad++;
         $display("FAIL busy_unpack: got %b want 1", bz0);
      end
      #2 rstn = 1'b0;
      #1;
      total++;
      if ({rdy0, rv0, bz0, res0, flg0} !== 40'd0) begin
         bad++;
         $display("FAIL async_reset: got %h want 0", {rdy0, rv0, bz0, res0, flg0});
      end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      total++;
      if ({rdy0, rv0} !== 2'b10) begin
         bad++;
         $display("FAIL ready_after_mid_reset: got %b want 10", {rdy0, rv0});
      end
      send(1'b0, 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 3'd0, 32'h40400000, 5'h00);
      wait_resp(1'b0, cyc);
      total++;
      e = (sb0.size() != 0) ? sb0.pop_front() : exp_t'(37'h0);
      if ({cyc == 3, res0, flg0} !== {1'b1, e.res, e.flg}) begin
         bad++;
         $display("FAIL post_reset_op: got cyc=%0d %h/%b want cyc=3 %h/%b", cyc, res0, flg0, e.res, e.flg);
      end
      @(negedge clk);
   endtask

   initial begin
      rstn = 1'b0;
      v0 = 1'b0; f0 = 1'b0; rr0 = 1'b1;
      v1 = 1'b0; f1 = 1'b0; rr1 = 1'b1;
      rs1 = 32'd0; rs2 = 32'd0; sub = 1'b0; rm = 3'd0;
      test_reset();
      test_vectors();
      test_backpressure();
      test_flush_idle();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
